// File: rtl/mips_run_monitor.sv
// Run monitor for a small MIPS core: shadows register writebacks, detects halt
// (PC stable) or timeout, then compares one shadow register against an expected value.
module mips_run_monitor #(
  parameter int PC_W          = 13,
  parameter int DATA_W        = 16,
  parameter int NREG          = 8,
  parameter int CNT_W         = 16,
  parameter int MAX_CYCLES    = 20,
  parameter int STABLE_CYCLES = 3,
  parameter int ZERO_RO       = 1,
  localparam int AW           = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [AW-1:0]     expect_addr,
  input  logic [DATA_W-1:0] expect_data,
  input  logic [AW-1:0]     snap_sel,
  output logic [DATA_W-1:0] snap_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int ST_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_reg;
  logic [ST_W-1:0]   stable, stable_nxt;
  logic              first;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shadow [NREG];
  logic              pass_r, timeout_r;
  logic              launch, halt, tmo, wb_commit;

  always_comb begin
    launch     = 1'b0;
    stable_nxt = '0;
    halt       = 1'b0;
    tmo        = 1'b0;
    wb_commit  = 1'b0;
    state_nxt  = state;

    // The first RUN cycle always counts as a PC change.
    if (!first && (pc_in == pc_reg))
      stable_nxt = (stable == ST_MAX) ? stable : stable + 1'b1;

    case (state)
      S_IDLE, S_DONE: begin
        launch = start;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        halt      = (stable_nxt == ST_MAX);
        tmo       = !halt && (cnt == CNT_LAST);
        wb_commit = wb_en && !((ZERO_RO != 0) && (wb_addr == '0));
        if (halt || tmo) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_reg    <= '0;
      stable    <= '0;
      first     <= 1'b0;
      cnt       <= '0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        pc_reg    <= '0;
        stable    <= '0;
        first     <= 1'b1;
        cnt       <= '0;
        pass_r    <= 1'b0;
        timeout_r <= 1'b0;
        for (int unsigned i = 0; i < NREG; i++) shadow[i] <= '0;
      end else if (state == S_RUN) begin
        pc_reg <= pc_in;
        stable <= stable_nxt;
        first  <= 1'b0;
        // Counter freezes on the terminating cycle so it reports the halt/timeout cycle.
        if (!halt && !tmo) cnt <= cnt + 1'b1;
        if (tmo) timeout_r <= 1'b1;
        if (wb_commit) shadow[wb_addr] <= wb_data;
      end else if (state == S_CHECK) begin
        pass_r <= (shadow[expect_addr] == expect_data) && !timeout_r;
      end
    end
  end

  assign snap_data = shadow[snap_sel];
  assign busy      = (state == S_RUN) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign pass      = pass_r;
  assign timeout   = timeout_r;
  assign cycle_cnt = cnt;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: default instance plus a tie-case instance.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [12:0] pc_in = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0, expect_addr = '0, snap_sel = '0;
  logic [15:0] wb_data = '0, expect_data = '0;

  logic [15:0] snap_a, snap_b, cnt_a, cnt_b;
  logic        busy_a, done_a, pass_a, timeout_a;
  logic        busy_b, done_b, pass_b, timeout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_run_monitor dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pc_in(pc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .expect_addr(expect_addr), .expect_data(expect_data),
    .snap_sel(snap_sel), .snap_data(snap_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
    .cycle_cnt(cnt_a)
  );

  mips_run_monitor #(.STABLE_CYCLES(19), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pc_in(pc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .expect_addr(expect_addr), .expect_data(expect_data),
    .snap_sel(snap_sel), .snap_data(snap_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
    .cycle_cnt(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [12:0] pc, input logic we,
                      input logic [2:0] a, input logic [15:0] d);
    pc_in = pc; wb_en = we; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  // PC 0,1,2,3,3,3,3 with r3 <- 0x002A at PC=2; ends in CHECK.
  task automatic run_halt_seq();
    step(13'd0, 1'b0, 3'd0, 16'h0);
    step(13'd1, 1'b0, 3'd0, 16'h0);
    step(13'd2, 1'b1, 3'd3, 16'h002A);
    for (int i = 0; i < 4; i++) step(13'd3, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass_a); end
    checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_a); end
    @(negedge clk) rst = 1'b0;
    tick(); tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_wait_busy got %b want 0", busy_a); end
  endtask

  task automatic test_halt_pass();
    expect_addr = 3'd3; expect_data = 16'h002A; snap_sel = 3'd3;
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL start_cnt got %0d want 0", cnt_a); end
    step(13'd0, 1'b0, 3'd0, 16'h0);
    step(13'd1, 1'b0, 3'd0, 16'h0);
    step(13'd2, 1'b1, 3'd3, 16'h002A);
    checks++; if (snap_a !== 16'h002A) begin errors++; $display("FAIL snap_run got %h want 002a", snap_a); end
    start_a = 1'b1;
    step(13'd3, 1'b0, 3'd0, 16'h0);
    start_a = 1'b0;
    checks++; if (cnt_a !== 16'd4) begin errors++; $display("FAIL start_ignored_cnt got %0d want 4", cnt_a); end
    step(13'd3, 1'b0, 3'd0, 16'h0);
    step(13'd3, 1'b0, 3'd0, 16'h0);
    step(13'd3, 1'b0, 3'd0, 16'h0);
    checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL check_state busy=%b done=%b want 1 0", busy_a, done_a); end
    tick();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL halt_done got %b want 1", done_a); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL halt_pass got %b want 1", pass_a); end
    checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL halt_timeout got %b want 0", timeout_a); end
    checks++; if (cnt_a !== 16'd6) begin errors++; $display("FAIL halt_cnt got %0d want 6", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL done_busy got %b want 0", busy_a); end
    tick(); tick();
    checks++; if (done_a !== 1'b1 || cnt_a !== 16'd6 || pass_a !== 1'b1) begin errors++; $display("FAIL done_frozen done=%b cnt=%0d pass=%b want 1 6 1", done_a, cnt_a, pass_a); end
  endtask

  task automatic test_back_to_back_mismatch();
    expect_addr = 3'd3; expect_data = 16'h0029; snap_sel = 3'd3;
    start_a = 1'b1; tick(); start_a = 1'b0;
    checks++; if (done_a !== 1'b0 || pass_a !== 1'b0) begin errors++; $display("FAIL restart_clear done=%b pass=%b want 0 0", done_a, pass_a); end
    checks++; if (snap_a !== 16'h0000) begin errors++; $display("FAIL restart_shadow_clear got %h want 0000", snap_a); end
    run_halt_seq();
    tick();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL mismatch_done got %b want 1", done_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL mismatch_pass got %b want 0", pass_a); end
    checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL mismatch_timeout got %b want 0", timeout_a); end
  endtask

  task automatic test_timeout();
    expect_addr = 3'd1; expect_data = 16'h0000;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 0; k < 19; k++) step(13'(k), 1'b0, 3'd0, 16'h0);
    checks++; if (cnt_a !== 16'd19 || busy_a !== 1'b1 || timeout_a !== 1'b0) begin errors++; $display("FAIL pre_timeout cnt=%0d busy=%b tmo=%b want 19 1 0", cnt_a, busy_a, timeout_a); end
    step(13'd19, 1'b0, 3'd0, 16'h0);
    checks++; if (timeout_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL timeout_check tmo=%b busy=%b want 1 1", timeout_a, busy_a); end
    tick();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL timeout_done got %b want 1", done_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL timeout_pass got %b want 0", pass_a); end
    checks++; if (cnt_a !== 16'd19) begin errors++; $display("FAIL timeout_cnt got %0d want 19", cnt_a); end
  endtask

  task automatic test_tie();
    expect_addr = 3'd1; expect_data = 16'h0055;
    start_b = 1'b1; tick(); start_b = 1'b0;
    step(13'd5, 1'b1, 3'd1, 16'h0055);
    for (int k = 1; k < 19; k++) step(13'd5, 1'b0, 3'd0, 16'h0);
    checks++; if (cnt_b !== 16'd19 || busy_b !== 1'b1) begin errors++; $display("FAIL tie_pre cnt=%0d busy=%b want 19 1", cnt_b, busy_b); end
    step(13'd5, 1'b0, 3'd0, 16'h0);
    tick();
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL tie_done got %b want 1", done_b); end
    checks++; if (timeout_b !== 1'b0) begin errors++; $display("FAIL tie_timeout got %b want 0", timeout_b); end
    checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL tie_pass got %b want 1", pass_b); end
    checks++; if (cnt_b !== 16'd19) begin errors++; $display("FAIL tie_cnt got %0d want 19", cnt_b); end
  endtask

  task automatic test_zero_snapshot();
    expect_addr = 3'd7; expect_data = 16'h1234;
    start_a = 1'b1; tick(); start_a = 1'b0;
    snap_sel = 3'd0;
    step(13'd0, 1'b1, 3'd0, 16'hFFFF);
    checks++; if (snap_a !== 16'h0000) begin errors++; $display("FAIL zero_ro got %h want 0000", snap_a); end
    snap_sel = 3'd7;
    step(13'd1, 1'b1, 3'd7, 16'h1234);
    checks++; if (snap_a !== 16'h1234) begin errors++; $display("FAIL snap_r7 got %h want 1234", snap_a); end
    for (int i = 0; i < 4; i++) step(13'd2, 1'b0, 3'd0, 16'h0);
    tick();
    checks++; if (done_a !== 1'b1 || pass_a !== 1'b1) begin errors++; $display("FAIL zero_run done=%b pass=%b want 1 1", done_a, pass_a); end
    step(13'd2, 1'b1, 3'd7, 16'hBEEF);
    checks++; if (snap_a !== 16'h1234) begin errors++; $display("FAIL done_write_ignored got %h want 1234", snap_a); end
    snap_sel = 3'd0;
    #1;
    checks++; if (snap_a !== 16'h0000) begin errors++; $display("FAIL snap_r0 got %h want 0000", snap_a); end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    snap_sel = 3'd3;
    start_a = 1'b1; tick(); start_a = 1'b0;
    step(13'd0, 1'b0, 3'd0, 16'h0);
    step(13'd1, 1'b1, 3'd3, 16'h0077);
    for (int k = 2; k < 5; k++) step(13'(k), 1'b0, 3'd0, 16'h0);
    checks++; if (cnt_a !== 16'd5 || snap_a !== 16'h0077) begin errors++; $display("FAIL abort_pre cnt=%0d snap=%h want 5 0077", cnt_a, snap_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || timeout_a !== 1'b0) begin errors++; $display("FAIL abort_flags busy=%b done=%b pass=%b tmo=%b want 0 0 0 0", busy_a, done_a, pass_a, timeout_a); end
    checks++; if (cnt_a !== 16'd0 || snap_a !== 16'h0000) begin errors++; $display("FAIL abort_state cnt=%0d snap=%h want 0 0000", cnt_a, snap_a); end
    @(negedge clk) rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(13'(i), 1'b0, 3'd0, 16'h0);
      if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_idle got activity=%b want 0", saw_done); end
    expect_addr = 3'd3; expect_data = 16'h002A;
    start_a = 1'b1; tick(); start_a = 1'b0;
    run_halt_seq();
    tick();
    checks++; if (done_a !== 1'b1 || pass_a !== 1'b1 || cnt_a !== 16'd6) begin errors++; $display("FAIL clean_rerun done=%b pass=%b cnt=%0d want 1 1 6", done_a, pass_a, cnt_a); end
  endtask

  initial begin
    test_reset();
    test_halt_pass();
    test_back_to_back_mismatch();
    test_timeout();
    test_tie();
    test_zero_snapshot();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
